// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port scratch-RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 2;
    localparam int N_REQ      = 2;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_A,
        RD_D
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side valid/ready bus: two requesters packed side by side.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: contention goes to the requester not granted last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant,
    output logic       sel
);
    always_comb begin
        sel   = 1'b0;
        grant = 2'b00;
        unique case (1'b1)
            (valid == 2'b11): sel = ~last;
            (valid == 2'b10): sel = 1'b1;
            default:          sel = 1'b0;
        endcase
        if (valid != 2'b00) begin
            grant = sel ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto the scratch RAM and sequences we/oe timing.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      bus,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_owner;
    logic                r_last;
    logic [N_REQ-1:0]    r_rsp_valid;
    logic [N_REQ-1:0]    w_grant;
    logic [N_REQ-1:0]    w_ready;
    logic                w_sel;
    logic                w_accept;
    logic                w_done;

    rr_arb2 u_arb (
        .valid (bus.req_valid),
        .last  (r_last),
        .grant (w_grant),
        .sel   (w_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = '0;
        w_accept = 1'b0;
        w_done   = 1'b0;
        ram_we   = 1'b0;
        ram_oe   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready  = rst_n ? w_grant : '0;
                w_accept = |w_grant;
                if (w_accept) begin
                    w_next = bus.req_write[w_sel] ? WR : RD_A;
                end
            end
            WR: begin
                ram_we = 1'b1;
                w_done = 1'b1;
                w_next = IDLE;
            end
            RD_A: begin
                ram_oe = 1'b1;
                w_next = RD_D;
            end
            RD_D: begin
                ram_oe = 1'b1;
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // ram_rdata is only trusted in RD_D, where oe has covered the RAM's read edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_addr  <= bus.req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                r_wdata <= bus.req_wdata[int'(w_sel)*DATA_W +: DATA_W];
                r_owner <= w_sel;
                r_last  <= w_sel;
            end
            if (w_done) begin
                r_rsp_valid <= N_REQ'(1) << r_owner;
            end
            if (r_state == RD_D) begin
                r_rdata <= ram_rdata;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign ram_addr      = r_addr;
    assign ram_wdata     = r_wdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed cases plus random traffic against a
// transaction-level model of grants, latencies and a 16x2 memory.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(4), .DATA_W(2)) bus ();

    logic       ram_we;
    logic       ram_oe;
    logic [3:0] ram_addr;
    logic [1:0] ram_wdata;
    wire  [1:0] ram_rdata;

    ram_arbiter #(.ADDR_W(4), .DATA_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Scratch RAM: synchronous write, registered read, tri-stated output
    logic [1:0] mem [16] = '{default: 2'b00};
    logic [1:0] oreg = 2'b00;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_oe) oreg <= mem[ram_addr];
    end
    assign ram_rdata = ram_oe ? oreg : 2'bzz;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [1:0] ref_mem [16];
    int         cyc;
    int         busy_until;
    int         acc_cyc;
    bit         acc_wr;
    logic [3:0] acc_addr;
    logic [1:0] acc_data;
    int         pend_at;
    logic [1:0] pend_vec;
    bit         pend_rd;
    logic [1:0] pend_rdata;
    logic [1:0] exp_rdata;
    int         last_g;

    task automatic model_reset();
        busy_until = cyc;
        acc_cyc    = -10;
        acc_wr     = 1'b0;
        pend_at    = -10;
        pend_vec   = 2'b00;
        pend_rd    = 1'b0;
        last_g     = 1;
        exp_rdata  = 2'b00;
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] w,
                        input logic [7:0] a, input logic [3:0] d);
        logic [1:0] er;
        int         s;
        bit         exp_we;
        bit         exp_oe;
        er = 2'b00;
        s  = 0;
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #1;
        if (cyc >= busy_until && v != 2'b00) begin
            if (v == 2'b11) s = 1 - last_g;
            else s = v[1] ? 1 : 0;
            er[s] = 1'b1;
        end
        exp_we = acc_wr && (cyc == acc_cyc + 1);
        exp_oe = !acc_wr && (cyc == acc_cyc + 1 || cyc == acc_cyc + 2);
        if (cyc == pend_at && pend_rd) exp_rdata = pend_rdata;
        chk("req_ready", bus.req_ready, er);
        chk("rsp_valid", bus.rsp_valid,
            (cyc == pend_at) ? pend_vec : 2'b00);
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk("ram_we", ram_we, exp_we);
        chk("ram_oe", ram_oe, exp_oe);
        chk("we_oe_excl", ram_we & ram_oe, 0);
        if (exp_we || exp_oe) chk("ram_addr", ram_addr, acc_addr);
        if (exp_we) chk("ram_wdata", ram_wdata, acc_data);
        if (er != 2'b00) begin
            last_g   = s;
            acc_cyc  = cyc;
            acc_wr   = w[s];
            acc_addr = a[s*4 +: 4];
            acc_data = d[s*2 +: 2];
            pend_vec = er;
            if (acc_wr) begin
                ref_mem[acc_addr] = acc_data;
                pend_rd    = 1'b0;
                pend_at    = cyc + 2;
                busy_until = cyc + 2;
            end else begin
                pend_rd    = 1'b1;
                pend_rdata = ref_mem[acc_addr];
                pend_at    = cyc + 3;
                busy_until = cyc + 3;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 8'h00, 4'h0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_oe", ram_oe, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 2'b00;
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 4'h0;
        cyc = 0;
        model_reset();

        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // requester 0 writes 3 to address 5, requester 1 reads it back
        step(2'b01, 2'b01, {4'h0, 4'h5}, {2'b00, 2'b11});
        idle(3);
        step(2'b10, 2'b00, {4'h5, 4'h0}, 4'h0);
        idle(4);

        // sustained contention alternates grants
        for (int i = 0; i < 12; i++) step(2'b11, 2'b00, {4'h1, 4'h0}, 4'h0);
        idle(4);

        // address 15 and 0 stay distinct; read right after write
        step(2'b01, 2'b01, {4'h0, 4'h0}, {2'b00, 2'b01});
        idle(2);
        step(2'b01, 2'b01, {4'h0, 4'hf}, {2'b00, 2'b10});
        step(2'b01, 2'b00, {4'h0, 4'hf}, 4'h0);
        step(2'b01, 2'b00, {4'h0, 4'hf}, 4'h0);
        idle(3);
        step(2'b01, 2'b00, {4'h0, 4'h0}, 4'h0);
        idle(3);

        // reset while the read sits in RD_D
        step(2'b10, 2'b00, {4'h7, 4'h0}, 4'h0);
        step(2'b00, 2'b00, 8'h00, 4'h0);
        bus.req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        model_reset();
        idle(4);
        step(2'b01, 2'b01, {4'h0, 4'h9}, {2'b00, 2'b01});
        idle(2);
        step(2'b10, 2'b00, {4'h9, 4'h0}, 4'h0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom),
                 8'($urandom), 4'($urandom));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the 16-word × 2-bit scratch RAM. Two requesters issue single-word read or write transactions through a valid/ready handshake. The block grants one requester at a time and drives the RAM's `we`/`oe`/`addr`/`data_in` pins with correct timing. For reads it holds `oe` across the RAM's registered read so the tri-stated `data_out` is stable when captured, then returns a one-cycle response to the owning requester.

## Interface
- `ADDR_W`, 4, RAM address width
- `DATA_W`, 2, RAM data width
- `clk` in 1: single clock, RAM clocked on the same edge
- `rst_n` in 1: reset, asynchronous and active-low
- `req_valid` in 2: per-requester transaction request
- `req_ready` out 2: per-requester accept, one-hot or zero
- `req_write` in 2: per-requester op, 1 = write, 0 = read
- `req_addr` in 2×ADDR_W: packed, requester i at `[i*ADDR_W +: ADDR_W]`
- `req_wdata` in 2×DATA_W: packed, same layout
- `rsp_valid` out 2: one-cycle completion pulse to the owning requester
- `rsp_rdata` out DATA_W: read data, shared, qualified by `rsp_valid`
- `ram_we` out 1: RAM write enable
- `ram_oe` out 1: RAM read/output enable
- `ram_addr` out ADDR_W: RAM address
- `ram_wdata` out DATA_W: RAM write data
- `ram_rdata` in DATA_W: RAM data_out, high-Z whenever `ram_oe` = 0

## Operation
- FSM states: IDLE, WR, RD_A, RD_D.
- IDLE:
  - Choose requester `sel`. If exactly one `req_valid` bit is set, that requester. If both are set, the requester ≠ `last_grant`.
  - `req_ready[sel]` = 1, combinational from `req_valid`; other bit 0.
  - Acceptance when valid & ready: latch `addr_q`, `wdata_q`, `op_q`, `owner_q` ← `sel`, `last_grant` ← `sel`. Next state is WR if write, RD_A if read.
- `req_ready` = 0 in every state except IDLE.
- WR: `ram_we` = 1. The RAM writes at the end of WR. Next state IDLE, with `rsp_valid[owner_q]` set for one cycle.
- RD_A: `ram_oe` = 1. The RAM loads its output register at the end of RD_A. Next state RD_D.
- RD_D: `ram_oe` = 1. `rsp_rdata` ← `ram_rdata` at the end of RD_D. Next state IDLE, with `rsp_valid[owner_q]` set.
- `ram_rdata` is sampled only in RD_D. Z/X on it in other states must not propagate.
- RAM-side outputs:
  - `ram_addr` = `addr_q` and `ram_wdata` = `wdata_q` at all times.
  - `ram_we`/`ram_oe` are decoded from the state register only; there is no combinational path from `req_*` to `ram_*`.
  - `ram_we` and `ram_oe` are never high together.
- `rsp_rdata` keeps its previous value on write completions.
- `req_*` inputs are ignored outside the acceptance cycle. A requester may drop `req_valid` without acceptance; there is no obligation to hold.

## Timing
- Reset values (async on `rst_n` low):
  - state IDLE; `last_grant` = 1, so requester 0 wins the first contention.
  - `addr_q`, `wdata_q`, `rsp_rdata` = 0.
  - `rsp_valid`, `ram_we`, `ram_oe` = 0.
  - `req_ready` = 0 while `rst_n` is low.
- Write, accepted at cycle T: WR at T+1; `rsp_valid` high at T+2, which is back in IDLE; a new acceptance is possible at T+2. Throughput is 1 write per 2 cycles.
- Read, accepted at cycle T: RD_A at T+1, RD_D at T+2; `rsp_valid` and `rsp_rdata` valid at T+3, where a new acceptance is possible. Throughput is 1 read per 3 cycles.
- Read after write to the same address returns the new data. The write completes at the end of WR, before any following RD_A.
- Back-to-back contention alternates grants 0,1,0,1. A lone requester is granted every IDLE cycle regardless of `last_grant`.
- Reset mid-transaction: the operation is aborted and no `rsp_valid` is issued. RAM contents are unchanged unless the WR edge had already occurred.

## Structure
- Package `ram_arb_pkg`: state enum (IDLE, WR, RD_A, RD_D), default `ADDR_W`/`DATA_W` localparams, and a requester-count constant of 2.
- Sub-module `rr_arb2` (combinational): inputs `valid[1:0]` and `last`; outputs one-hot `grant[1:0]` and `sel`. Instanced once.

## Test plan
- Reset, then requester 0 writes 0x3 to address 5 → `ram_we` high for exactly 1 cycle with `ram_addr`=5 and `ram_wdata`=3; `rsp_valid`=2'b01 at T+2.
- Requester 1 reads address 5 after the above → `ram_oe` high for 2 cycles; `rsp_valid`=2'b10 and `rsp_rdata`=3 at T+3.
- Both requesters hold reads of addresses 0 and 1 continuously → accepts alternate 0,1,0,1 starting with 0; each `rsp_valid` goes to the correct owner.
- Write 0x2 to address 15, then immediately read address 15 by the same requester → `rsp_rdata`=2. Address wraps nothing: address 15 and address 0 stay distinct.
- `rst_n` asserted during RD_D → all outputs 0 immediately; no `rsp_valid` after release; the next request is served normally from IDLE.
- Random mixed traffic against a 16×2 reference memory model → every response matches, `we`&`oe` never both high, and `ram_rdata` is never sampled while `oe`=0.
